bomb_sequence_ctrl: RTL and testbench

Round controller for the sequence-memory bomb module. It generates a random 4-symbol target sequence and drives the seven-segment sequence display in show mode for a fixed window. It then collects the player's entry from the Move/Next buttons and compares entry against target. It counts strikes and declares the module defused or exploded, and is the only writer of the display's mode and sequence inputs.

---
 rtl/bomb_sequence_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bomb_sequence_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_sequence_ctrl.sv
// Round controller for the sequence-memory bomb module: draws a random 4-symbol
// target, shows it, collects the player's entry, and tracks strikes to defuse/explode.
module bomb_sequence_ctrl #(
  parameter int          SHOW_CYCLES  = 1000,
  parameter int          ENTRY_CYCLES = 4000,
  parameter int          MAX_STRIKES  = 3,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        btn_move,
  input  logic        btn_next,
  output logic        display,
  output logic [15:0] seq_target,
  output logic [15:0] entry,
  output logic [1:0]  entry_pos,
  output logic [1:0]  strikes,
  output logic        busy,
  output logic        defused,
  output logic        exploded
);

  localparam int CNT_MAX = (SHOW_CYCLES > ENTRY_CYCLES) ? SHOW_CYCLES : ENTRY_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SHOW_LOAD  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_CYCLES - 1);
  localparam logic [1:0]    STRIKE_LIM = 2'(MAX_STRIKES);

  typedef enum logic [2:0] {
    IDLE, GEN, SHOW, ENTER, CHECK, DEFUSED, EXPLODED
  } state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [CW-1:0] cnt;
  logic          start_q, move_q, next_q;
  logic          start_p, move_p, next_p;
  logic [15:0]   entry_rot;
  logic [15:0]   target_gen;
  logic [1:0]    strikes_inc;

  function automatic logic [3:0] sym_map(input logic [1:0] v);
    logic [3:0] s;
    case (v)
      2'd0:    s = 4'b1110;
      2'd1:    s = 4'b1101;
      2'd2:    s = 4'b1011;
      2'd3:    s = 4'b0111;
      default: s = 4'b1110;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] sym_rot(input logic [3:0] d);
    return {d[2:0], d[3]};
  endfunction

  // Taps 16,14,13,11 of x^16+x^14+x^13+x^11+1, shifting towards the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  assign start_p     = start    & ~start_q;
  assign move_p      = btn_move & ~move_q;
  assign next_p      = btn_next & ~next_q;
  assign strikes_inc = strikes + 2'd1;
  assign target_gen  = {sym_map(lfsr[7:6]), sym_map(lfsr[5:4]),
                        sym_map(lfsr[3:2]), sym_map(lfsr[1:0])};

  always_comb begin
    entry_rot = entry;
    case (entry_pos)
      2'd0:    entry_rot[3:0]   = sym_rot(entry[3:0]);
      2'd1:    entry_rot[7:4]   = sym_rot(entry[7:4]);
      2'd2:    entry_rot[11:8]  = sym_rot(entry[11:8]);
      2'd3:    entry_rot[15:12] = sym_rot(entry[15:12]);
      default: entry_rot = entry;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= SEED;
      cnt        <= '0;
      start_q    <= 1'b0;
      move_q     <= 1'b0;
      next_q     <= 1'b0;
      display    <= 1'b0;
      seq_target <= 16'hFFFF;
      entry      <= 16'hEEEE;
      entry_pos  <= 2'd0;
      strikes    <= 2'd0;
      busy       <= 1'b0;
      defused    <= 1'b0;
      exploded   <= 1'b0;
    end else begin
      lfsr    <= lfsr_step(lfsr);
      start_q <= start;
      move_q  <= btn_move;
      next_q  <= btn_next;
      case (state)
        IDLE: begin
          if (start_p) begin
            state <= GEN;
            busy  <= 1'b1;
          end
        end
        GEN: begin
          seq_target <= target_gen;
          strikes    <= 2'd0;
          display    <= 1'b1;
          cnt        <= SHOW_LOAD;
          state      <= SHOW;
        end
        SHOW: begin
          if (cnt == '0) begin
            state     <= ENTER;
            display   <= 1'b0;
            entry     <= 16'hEEEE;
            entry_pos <= 2'd0;
            cnt       <= ENTRY_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ENTER: begin
          // Next beats both a simultaneous move and an expiring timer.
          if (next_p) begin
            if (entry_pos == 2'd3) state <= CHECK;
            else                   entry_pos <= entry_pos + 2'd1;
            if (cnt != '0) cnt <= cnt - 1'b1;
          end else if (cnt == '0) begin
            state <= CHECK;
          end else begin
            if (move_p) entry <= entry_rot;
            cnt <= cnt - 1'b1;
          end
        end
        CHECK: begin
          if (entry == seq_target) begin
            state   <= DEFUSED;
            defused <= 1'b1;
            busy    <= 1'b0;
          end else if (strikes_inc == STRIKE_LIM) begin
            state    <= EXPLODED;
            strikes  <= strikes_inc;
            exploded <= 1'b1;
            busy     <= 1'b0;
          end else begin
            state   <= SHOW;
            strikes <= strikes_inc;
            display <= 1'b1;
            cnt     <= SHOW_LOAD;
          end
        end
        DEFUSED, EXPLODED: begin
          if (start_p) begin
            state    <= GEN;
            busy     <= 1'b1;
            defused  <= 1'b0;
            exploded <= 1'b0;
            strikes  <= 2'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_sequence_ctrl.sv
// Self-checking bench for bomb_sequence_ctrl: table-driven rotation vectors plus
// a scoreboard for entry/cursor updates and hand-written round sequences.
module tb_bomb_sequence_ctrl;

  localparam int          SHOW1  = 6;
  localparam int          ENTRY1 = 40;
  localparam int          SHOW2  = 4;
  localparam int          ENTRY2 = 10;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [39:0] RST_VEC = {1'b0, 16'hFFFF, 16'hEEEE, 2'd0, 2'd0, 3'd0};

  logic        clk, reset, start, btn_move, btn_next;
  logic        display, busy, defused, exploded;
  logic [15:0] seq_target, entry;
  logic [1:0]  entry_pos, strikes;

  logic        start2, move2, next2;
  logic        display2, busy2, defused2, exploded2;
  logic [15:0] seq_target2, entry2;
  logic [1:0]  entry_pos2, strikes2;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  logic [15:0] m_entry;
  logic [1:0]  m_pos;
  logic [15:0] tgt;

  typedef struct packed {
    logic [15:0] entry;
    logic [1:0]  pos;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic       move;
    logic       next;
    logic [3:0] exp_d0;
    logic [1:0] exp_pos;
  } vec_t;
  vec_t rot_tab[5];

  bomb_sequence_ctrl #(.SHOW_CYCLES(SHOW1), .ENTRY_CYCLES(ENTRY1), .MAX_STRIKES(3), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .btn_move(btn_move), .btn_next(btn_next),
    .display(display), .seq_target(seq_target), .entry(entry), .entry_pos(entry_pos),
    .strikes(strikes), .busy(busy), .defused(defused), .exploded(exploded));

  bomb_sequence_ctrl #(.SHOW_CYCLES(SHOW2), .ENTRY_CYCLES(ENTRY2), .MAX_STRIKES(3), .SEED(SEED)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .btn_move(move2), .btn_next(next2),
    .display(display2), .seq_target(seq_target2), .entry(entry2), .entry_pos(entry_pos2),
    .strikes(strikes2), .busy(busy2), .defused(defused2), .exploded(exploded2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR tracking the DUT's free-running generator.
  always @(posedge clk) m_lfsr <= reset ? SEED : lfsr_next(m_lfsr);

  function automatic logic [3:0] sym(input logic [1:0] v);
    case (v)
      2'd0:    return 4'b1110;
      2'd1:    return 4'b1101;
      2'd2:    return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic int sym_idx(input logic [3:0] d);
    case (d)
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] decode(input logic [15:0] l);
    return {sym(l[7:6]), sym(l[5:4]), sym(l[3:2]), sym(l[1:0])};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one button pulse (one cycle high, one low); expected state goes via the scoreboard.
  task automatic press(input logic mv, input logic nx);
    exp_t e;
    int   idx;
    btn_move = mv;
    btn_next = nx;
    idx = int'(m_pos) * 4;
    if (nx) begin
      if (m_pos != 2'd3) m_pos = m_pos + 2'd1;
    end else if (mv) begin
      m_entry[idx +: 4] = {m_entry[idx+2 -: 3], m_entry[idx+3]};
    end
    e.entry = m_entry;
    e.pos   = m_pos;
    sbq.push_back(e);
    @(negedge clk);
    btn_move = 1'b0;
    btn_next = 1'b0;
    e = sbq.pop_front();
    chk("entry", {48'd0, entry}, {48'd0, e.entry});
    chk("entry_pos", {62'd0, entry_pos}, {62'd0, e.pos});
    @(negedge clk);
  endtask

  // Called at the negedge of the first SHOW cycle; returns in the first ENTER cycle.
  task automatic show_phase(input logic [15:0] exp_tgt);
    int n;
    chk("show_display", {63'd0, display}, 64'd1);
    chk("seq_target", {48'd0, seq_target}, {48'd0, exp_tgt});
    n = 0;
    while (display && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("show_len", n, SHOW1);
    m_entry = 16'hEEEE;
    m_pos   = 2'd0;
    chk("enter_entry_init", {48'd0, entry}, {48'd0, 16'hEEEE});
    chk("enter_pos_init", {62'd0, entry_pos}, 64'd0);
  endtask

  task automatic start_round(output logic [15:0] t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("gen_busy", {63'd0, busy}, 64'd1);
    chk("gen_display", {63'd0, display}, 64'd0);
    chk("gen_strikes", {62'd0, strikes}, 64'd0);
    chk("gen_flags", {62'd0, defused, exploded}, 64'd0);
    t = decode(m_lfsr);
    @(negedge clk);
    show_phase(t);
  endtask

  // Advance cursor to digit 3, force a mismatch if needed, then submit.
  task automatic wrong_attempt(input logic [15:0] t);
    while (m_pos != 2'd3) press(1'b0, 1'b1);
    if (m_entry == t) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
  endtask

  initial begin
    int n;
    rot_tab[0] = '{1'b1, 1'b0, 4'b1101, 2'd0};
    rot_tab[1] = '{1'b1, 1'b0, 4'b1011, 2'd0};
    rot_tab[2] = '{1'b1, 1'b0, 4'b0111, 2'd0};
    rot_tab[3] = '{1'b1, 1'b0, 4'b1110, 2'd0};
    rot_tab[4] = '{1'b1, 1'b1, 4'b1110, 2'd1};

    reset = 1'b1; start = 1'b0; btn_move = 1'b0; btn_next = 1'b0;
    start2 = 1'b0; move2 = 1'b0; next2 = 1'b0;
    m_entry = 16'hEEEE; m_pos = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_vals", {24'd0, display, seq_target, entry, entry_pos, strikes, busy, defused, exploded},
        {24'd0, RST_VEC});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_hold", {24'd0, display, seq_target, entry, entry_pos, strikes, busy, defused, exploded},
          {24'd0, RST_VEC});
    end

    // Correct entry with minimal presses.
    start_round(tgt);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < sym_idx(tgt[i*4 +: 4]); j++) press(1'b1, 1'b0);
      press(1'b0, 1'b1);
    end
    chk("defused", {63'd0, defused}, 64'd1);
    chk("defused_strikes", {62'd0, strikes}, 64'd0);
    chk("defused_busy", {63'd0, busy}, 64'd0);
    chk("defused_entry", {48'd0, entry}, {48'd0, tgt});

    // Rotation table, then three wrong submissions.
    start_round(tgt);
    for (int i = 0; i < 5; i++) begin
      press(rot_tab[i].move, rot_tab[i].next);
      chk("rot_digit0", {60'd0, entry[3:0]}, {60'd0, rot_tab[i].exp_d0});
      chk("rot_pos", {62'd0, entry_pos}, {62'd0, rot_tab[i].exp_pos});
    end
    for (int s = 1; s <= 3; s++) begin
      wrong_attempt(tgt);
      if (s < 3) begin
        chk("strike_count", {62'd0, strikes}, s);
        show_phase(tgt);
      end else begin
        chk("exploded", {63'd0, exploded}, 64'd1);
        chk("explode_strikes", {62'd0, strikes}, 64'd3);
        chk("explode_busy", {63'd0, busy}, 64'd0);
        chk("explode_display", {63'd0, display}, 64'd0);
      end
    end

    // Timeout on the short-timer instance.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (!display2 && n < 50) begin n++; @(negedge clk); end
    while (display2 && n < 50) begin n++; @(negedge clk); end
    chk("to_entry_init", {48'd0, entry2}, {48'd0, 16'hEEEE});
    n = 0;
    while (!display2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_check_delay", n, ENTRY2 + 1);
    chk("to_strikes", {62'd0, strikes2}, 64'd1);

    // Restart after explosion, then reset in the 5th ENTER cycle.
    start_round(tgt);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_vals", {24'd0, display, seq_target, entry, entry_pos, strikes, busy, defused, exploded},
        {24'd0, RST_VEC});
    reset = 1'b0;
    start_round(tgt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
